// File: rtl/pangya_meter_if.sv
// rtl/pangya_meter_if.sv - pixel/control bundle between the game logic and the shot meter
interface pangya_meter_if;
  logic [9:0]  xx;
  logic [9:0]  yy;
  logic        aactive;
  logic        frame_tick;
  logic        start;
  logic        hit;
  logic        meterOn;
  logic [11:0] meter_color;
  logic        done;
  logic [1:0]  grade;
  logic        busy;

  modport master (
    output xx, yy, aactive, frame_tick, start, hit,
    input  meterOn, meter_color, done, grade, busy
  );

  modport slave (
    input  xx, yy, aactive, frame_tick, start, hit,
    output meterOn, meter_color, done, grade, busy
  );
endinterface

// File: rtl/pangya_meter.sv
// rtl/pangya_meter.sv - animated shot meter: sweeping cursor over a green/yellow/red bar, graded on hit
module pangya_meter #(
  parameter int BAR_X0      = 220,
  parameter int BAR_Y0      = 301,
  parameter int BAR_W       = 160,
  parameter int BAR_H       = 5,
  parameter int ZONE0_HALF  = 10,
  parameter int ZONE1_HALF  = 40,
  parameter int STEP        = 2,
  parameter int CURSOR_W    = 2,
  parameter int MAX_PASSES  = 6,
  parameter int HOLD_FRAMES = 60
) (
  input logic           Pclk,
  input logic           reset,
  pangya_meter_if.slave m
);
  localparam int PW  = $clog2(BAR_W);
  localparam int PSW = $clog2(MAX_PASSES + 1);
  localparam int HW  = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_t;

  state_t         state;
  logic [PW-1:0]  pos;
  logic           dir_left;
  logic [PSW-1:0] passes;
  logic [HW-1:0]  hold_cnt;
  logic           hit_q;
  logic           done_r, busy_r, on_r;
  logic [1:0]     grade_r;
  logic [11:0]    color_r;

  function automatic logic [10:0] absdiff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic logic [1:0] zone(input logic [10:0] d);
    if (d < 11'(ZONE0_HALF))      return 2'd0;
    else if (d < 11'(ZONE1_HALF)) return 2'd1;
    else                          return 2'd2;
  endfunction

  logic           hit_edge;
  logic [10:0]    cursor_d;
  logic [PW-1:0]  pos_nx;
  logic           dir_nx, bounce;
  logic [PSW-1:0] passes_nx;

  assign hit_edge  = m.hit & ~hit_q;
  assign cursor_d  = absdiff(11'(pos) + 11'(CURSOR_W / 2), 11'(BAR_W / 2));
  assign passes_nx = passes + PSW'(bounce);

  // One frame step of the cursor, clamping to the bar ends and flipping direction there.
  always_comb begin
    pos_nx = pos;
    dir_nx = dir_left;
    bounce = 1'b0;
    if (!dir_left) begin
      if (11'(pos) + 11'(STEP) >= 11'(BAR_W - 1)) begin
        pos_nx = PW'(BAR_W - 1);
        dir_nx = 1'b1;
        bounce = 1'b1;
      end else begin
        pos_nx = pos + PW'(STEP);
      end
    end else begin
      if (11'(pos) <= 11'(STEP)) begin
        pos_nx = '0;
        dir_nx = 1'b0;
        bounce = 1'b1;
      end else begin
        pos_nx = pos - PW'(STEP);
      end
    end
  end

  always_ff @(posedge Pclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= '0;
      dir_left <= 1'b0;
      passes   <= '0;
      hold_cnt <= '0;
      hit_q    <= 1'b0;
      done_r   <= 1'b0;
      grade_r  <= 2'd0;
      busy_r   <= 1'b0;
    end else begin
      hit_q  <= m.hit;
      done_r <= 1'b0;
      case (state)
        IDLE: if (m.start) begin
          state    <= SWEEP;
          busy_r   <= 1'b1;
          pos      <= '0;
          dir_left <= 1'b0;
          passes   <= '0;
        end
        // A hit edge is graded on the pre-step position and suppresses that cycle's step.
        SWEEP: if (hit_edge) begin
          state    <= HOLD;
          grade_r  <= zone(cursor_d);
          done_r   <= 1'b1;
          hold_cnt <= '0;
        end else if (m.frame_tick) begin
          pos      <= pos_nx;
          dir_left <= dir_nx;
          passes   <= passes_nx;
          if (passes_nx == PSW'(MAX_PASSES)) begin
            state    <= HOLD;
            grade_r  <= 2'd3;
            done_r   <= 1'b1;
            hold_cnt <= '0;
          end
        end
        HOLD: if (m.frame_tick) begin
          if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Pixel path; 11-bit zero-extended compares keep xx < BAR_X0 from wrapping into the bar.
  logic [10:0] xx_w, yy_w, rx, cur_x0;
  logic        in_bar, in_cur;

  assign xx_w   = {1'b0, m.xx};
  assign yy_w   = {1'b0, m.yy};
  assign rx     = xx_w - 11'(BAR_X0);
  assign cur_x0 = 11'(BAR_X0) + 11'(pos);
  assign in_bar = (xx_w >= 11'(BAR_X0)) && (xx_w <= 11'(BAR_X0 + BAR_W - 1)) &&
                  (yy_w >= 11'(BAR_Y0)) && (yy_w <= 11'(BAR_Y0 + BAR_H - 1));
  assign in_cur = (state != IDLE) &&
                  (xx_w >= cur_x0) && (xx_w <= cur_x0 + 11'(CURSOR_W - 1)) &&
                  (yy_w >= 11'(BAR_Y0 - 2)) && (yy_w <= 11'(BAR_Y0 + BAR_H + 1));

  always_ff @(posedge Pclk or posedge reset) begin
    if (reset) begin
      on_r    <= 1'b0;
      color_r <= 12'h000;
    end else if (m.aactive && in_cur) begin
      on_r    <= 1'b1;
      color_r <= 12'hFFF;
    end else if (m.aactive && in_bar) begin
      on_r <= 1'b1;
      case (zone(absdiff(rx, 11'(BAR_W / 2))))
        2'd0:    color_r <= 12'h0F0;
        2'd1:    color_r <= 12'hDF0;
        default: color_r <= 12'hE20;
      endcase
    end else begin
      on_r    <= 1'b0;
      color_r <= 12'h000;
    end
  end

  assign m.meterOn     = on_r;
  assign m.meter_color = color_r;
  assign m.done        = done_r;
  assign m.grade       = grade_r;
  assign m.busy        = busy_r;
endmodule

// File: tb/tb_pangya_meter.sv
// tb/tb_pangya_meter.sv - self-checking bench for pangya_meter
module tb_pangya_meter;
  localparam int X0 = 220, Y0 = 301, W = 160, H = 5, Z0 = 10, Z1 = 40;
  localparam int STEP = 2, CW = 2, MAXP = 6, HOLDF = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt = 0, pass_cnt = 0, done_cnt = 0;

  pangya_meter_if mif();
  pangya_meter dut (.Pclk(clk), .reset(rst), .m(mif));

  always #20 clk = ~clk;

  typedef struct {
    int x; int y; bit act; bit on; int col;
  } pix_vec_t;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (mif.done) done_cnt++;
  endtask

  // Cursor trajectory from the number of frame ticks since start: whole passes of equal length.
  function automatic int traj_pos(input int k, output int np);
    int  t = k;
    int  len = (W - 1 + STEP - 1) / STEP;
    bit  left = 1'b0;
    np = 0;
    while (t >= len) begin
      t -= len;
      np++;
      left = !left;
    end
    return left ? (W - 1) - STEP * t : STEP * t;
  endfunction

  function automatic int zone_of(input int d);
    int a = (d < 0) ? -d : d;
    return (a < Z0) ? 0 : (a < Z1) ? 1 : 2;
  endfunction

  function automatic int exp_color(input int x, input int y, input bit act, input bit bz, input int p);
    int zc;
    if (!act) return 0;
    if (bz && x >= X0 + p && x < X0 + p + CW && y >= Y0 - 2 && y <= Y0 + H + 1) return 'hFFF;
    if (x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H) begin
      zc = zone_of(x - X0 - W / 2);
      return (zc == 0) ? 'h0F0 : (zc == 1) ? 'hDF0 : 'hE20;
    end
    return 0;
  endfunction

  task automatic probe(input string name, input int x, input int y, input bit act, input bit bz, input int p);
    int e;
    mif.xx = 10'(x);
    mif.yy = 10'(y);
    mif.aactive = act;
    cyc();
    e = exp_color(x, y, act, bz, p);
    check({name, ".on"}, int'(mif.meterOn), int'(e != 0));
    check({name, ".col"}, int'(mif.meter_color), e);
  endtask

  task automatic tick();
    mif.frame_tick = 1'b1;
    cyc();
    mif.frame_tick = 1'b0;
    repeat ($urandom_range(0, 1)) cyc();
  endtask

  task automatic hold_out(input string tag);
    repeat (HOLDF - 1) tick();
    check({tag, ".busy_hold"}, int'(mif.busy), 1);
    tick();
    check({tag, ".busy_idle"}, int'(mif.busy), 0);
  endtask

  task automatic run_round(input string tag, input int k, input bit coincide, input bit keep_hit);
    int np, p, d0;
    mif.start = 1'b1;
    cyc();
    mif.start = 1'b0;
    check({tag, ".busy"}, int'(mif.busy), 1);
    repeat (k) tick();
    p = traj_pos(k, np);
    probe({tag, ".cur"}, X0 + p, Y0 - 2, 1'b1, 1'b1, p);
    d0 = done_cnt;
    mif.hit = 1'b1;
    if (coincide) mif.frame_tick = 1'b1;
    cyc();
    mif.frame_tick = 1'b0;
    check({tag, ".done"}, int'(mif.done), 1);
    check({tag, ".grade"}, int'(mif.grade), zone_of(p + CW / 2 - W / 2));
    cyc();
    check({tag, ".done_low"}, int'(mif.done), 0);
    if (!keep_hit) mif.hit = 1'b0;
    probe({tag, ".frozen"}, X0 + p, Y0 - 2, 1'b1, 1'b1, p);
    probe({tag, ".past"}, X0 + p + CW, Y0 - 2, 1'b1, 1'b1, p);
    hold_out(tag);
    check({tag, ".done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_vec_t vt[10];
    int np, p, d0, pos_k;
    mif.xx = '0; mif.yy = '0; mif.aactive = 1'b0;
    mif.frame_tick = 1'b0; mif.start = 1'b0; mif.hit = 1'b0;

    vt[0] = '{x: 300, y: 303, act: 1'b1, on: 1'b1, col: 'h0F0};
    vt[1] = '{x: 270, y: 303, act: 1'b1, on: 1'b1, col: 'hDF0};
    vt[2] = '{x: 230, y: 303, act: 1'b1, on: 1'b1, col: 'hE20};
    vt[3] = '{x: 219, y: 303, act: 1'b1, on: 1'b0, col: 'h000};
    vt[4] = '{x: 300, y: 303, act: 1'b0, on: 1'b0, col: 'h000};
    vt[5] = '{x: 379, y: 301, act: 1'b1, on: 1'b1, col: 'hE20};
    vt[6] = '{x: 380, y: 303, act: 1'b1, on: 1'b0, col: 'h000};
    vt[7] = '{x: 290, y: 305, act: 1'b1, on: 1'b1, col: 'hDF0};
    vt[8] = '{x: 300, y: 306, act: 1'b1, on: 1'b0, col: 'h000};
    vt[9] = '{x: 310, y: 300, act: 1'b1, on: 1'b0, col: 'h000};

    repeat (2) cyc();
    check("rst.on", int'(mif.meterOn), 0);
    check("rst.col", int'(mif.meter_color), 0);
    check("rst.done", int'(mif.done), 0);
    check("rst.grade", int'(mif.grade), 0);
    check("rst.busy", int'(mif.busy), 0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 10; i++) begin
      mif.xx = 10'(vt[i].x);
      mif.yy = 10'(vt[i].y);
      mif.aactive = vt[i].act;
      cyc();
      check($sformatf("vec%0d.on", i), int'(mif.meterOn), int'(vt[i].on));
      check($sformatf("vec%0d.col", i), int'(mif.meter_color), vt[i].col);
    end

    for (int i = 0; i < 30; i++)
      probe($sformatf("idle_rnd%0d", i), $urandom_range(200, 400), $urandom_range(296, 310),
            1'($urandom_range(0, 3) != 0), 1'b0, 0);

    run_round("perfect", 40, 1'b0, 1'b0);
    run_round("good", 25, 1'b0, 1'b0);
    run_round("poor", 5, 1'b0, 1'b0);

    // No hit: bounces at both ends, then auto-miss on the sixth pass.
    mif.start = 1'b1;
    cyc();
    mif.start = 1'b0;
    d0 = done_cnt;
    for (int k = 1; k < (W / STEP) * MAXP; k++) begin
      tick();
      if (k == 79 || k == 80 || k == 81 || k == 160 || k == 161) begin
        p = traj_pos(k, np);
        probe($sformatf("sweep_k%0d", k), X0 + p, Y0 - 2, 1'b1, 1'b1, p);
      end
    end
    check("miss.no_early_done", done_cnt - d0, 0);
    check("miss.busy", int'(mif.busy), 1);
    tick();
    check("miss.done_pulses", done_cnt - d0, 1);
    check("miss.grade", int'(mif.grade), 3);
    hold_out("miss");

    // Hit edge with a frame tick at pos 78, hit left high into the next round.
    run_round("coinc", 39, 1'b1, 1'b1);
    mif.start = 1'b1;
    cyc();
    mif.start = 1'b0;
    d0 = done_cnt;
    repeat (25) tick();
    check("held.no_done", done_cnt - d0, 0);
    check("held.busy", int'(mif.busy), 1);
    mif.hit = 1'b0;
    cyc();
    mif.hit = 1'b1;
    cyc();
    mif.hit = 1'b0;
    check("held.done", done_cnt - d0, 1);
    p = traj_pos(25, np);
    check("held.grade", int'(mif.grade), zone_of(p + CW / 2 - W / 2));
    hold_out("held");

    for (int r = 0; r < 8; r++) begin
      pos_k = $urandom_range(0, 470);
      run_round($sformatf("rnd%0d_k%0d", r, pos_k), pos_k, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a sweep.
    mif.start = 1'b1;
    cyc();
    mif.start = 1'b0;
    repeat (20) tick();
    probe("mid.cur40", X0 + 40, Y0 - 2, 1'b1, 1'b1, 40);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("mid.on", int'(mif.meterOn), 0);
    check("mid.col", int'(mif.meter_color), 0);
    check("mid.busy", int'(mif.busy), 0);
    check("mid.grade", int'(mif.grade), 0);
    mif.hit = 1'b1;
    repeat (3) cyc();
    mif.hit = 1'b0;
    rst = 1'b0;
    repeat (3) cyc();
    check("mid.no_done", done_cnt - d0, 0);
    mif.start = 1'b1;
    cyc();
    mif.start = 1'b0;
    probe("mid.restart0", X0, Y0 - 2, 1'b1, 1'b1, 0);
    probe("mid.restart40", X0 + 40, Y0 - 2, 1'b1, 1'b1, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
